// File: rtl/pc_gen_ras_pkg.sv
// Shared constants and redirect-priority encoding
// for the next-PC generator and its return-address stack.
package pc_gen_ras_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

  typedef logic [2:0] pc_sel_t;

  localparam pc_sel_t SEL_EXC  = 3'd0;
  localparam pc_sel_t SEL_ERET = 3'd1;
  localparam pc_sel_t SEL_HOLD = 3'd2;
  localparam pc_sel_t SEL_BR   = 3'd3;
  localparam pc_sel_t SEL_SEQ  = 3'd4;

  function automatic pc_sel_t pc_sel(
    input logic exc,
    input logic eret,
    input logic stall,
    input logic br
  );
    if (exc)        return SEL_EXC;
    else if (eret)  return SEL_ERET;
    else if (stall) return SEL_HOLD;
    else if (br)    return SEL_BR;
    else            return SEL_SEQ;
  endfunction

endpackage

// File: rtl/pc_gen_ras_ras_stack.sv
// Circular return-address stack with saturating
// count, sticky overflow and underflow pulse.
module ras_stack
  import pc_gen_ras_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] addr_i,
  output logic [WIDTH-1:0] top_o,
  output logic             valid_o,
  output logic             ovf_o,
  output logic             unf_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d, wptr;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             we;
  logic             full, empty;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = en_i & push_i;
  assign do_pop  = en_i & pop_i;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = 1'b0;
    we    = 1'b0;
    wptr  = ptr_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (do_push && (!do_pop || empty)) begin
      ptr_d = ptr_q + PW'(1);
      wptr  = ptr_q + PW'(1);
      we    = 1'b1;
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + CW'(1);
    end else if (do_push && do_pop) begin
      // call and return together: replace top in place
      we = 1'b1;
    end else if (do_pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        ptr_d = ptr_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[wptr] <= addr_i;
  end

  assign top_o   = empty ? '0 : mem_q[ptr_q];
  assign valid_o = ~empty;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

endmodule

// File: rtl/pc_gen_ras.sv
// Registered next-PC generator with redirect
// priority mux and return-address prediction.
module pc_gen_ras
  import pc_gen_ras_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(RESET_PC_DEF),
  parameter logic [WIDTH-1:0] EXC_PC    = WIDTH'(EXC_PC_DEF),
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             exc_valid,
  input  logic             eret_valid,
  input  logic [WIDTH-1:0] epc,
  input  logic             call_push,
  input  logic [WIDTH-1:0] push_addr,
  input  logic             ret_pop,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_valid,
  output logic             ras_overflow,
  output logic             ras_underflow,
  output logic             misalign
);

  logic [WIDTH-1:0] pc_q, pc_d, tgt;
  logic             mis_q, mis_d;
  logic             ld;
  pc_sel_t          sel;

  assign sel = pc_sel(exc_valid, eret_valid,
                      stall, redirect_valid);

  always_comb begin
    tgt  = '0;
    ld   = 1'b0;
    pc_d = pc_q;
    unique case (sel)
      SEL_EXC:  begin tgt = EXC_PC;      ld = 1'b1; end
      SEL_ERET: begin tgt = epc;         ld = 1'b1; end
      SEL_BR:   begin tgt = redirect_pc; ld = 1'b1; end
      SEL_SEQ:  pc_d = pc_q + WIDTH'(4);
      default:  pc_d = pc_q;
    endcase
    if (ld) pc_d = {tgt[WIDTH-1:2], 2'b00};
    mis_d = ld & (|tgt[1:0]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= RESET_PC;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
    end
  end

  assign pc       = pc_q;
  assign misalign = mis_q;

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (reset_n),
    .en_i    (~stall & ~exc_valid),
    .clr_i   (exc_valid),
    .push_i  (call_push),
    .pop_i   (ret_pop),
    .addr_i  (push_addr),
    .top_o   (ras_top),
    .valid_o (ras_valid),
    .ovf_o   (ras_overflow),
    .unf_o   (ras_underflow)
  );

endmodule

// File: doc/pc_gen_ras.md
Name: pc_gen_ras

Overview:
- Sequential next-PC generator for the pipelined MIPS core; successor to the combinational next-PC logic.
- Owns the architectural PC register and applies redirects by priority: exception entry, eret, resolved branch/jump, stall hold, sequential +4.
- Adds a parametrised return-address stack (RAS) that predicts jr $ra targets for the ID stage.
- Sits between the ID-stage branch/jump resolver and the IF-stage instruction memory address.

Parameters:
- WIDTH, 32, PC and address width in bits (>= 8).
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_PC, 32'h0000_4180, exception handler entry address.
- RAS_DEPTH, 4, number of RAS entries (power of two, >= 2).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard-unit stall; freezes PC and blocks RAS updates.
- redirect_valid  in  1  ID resolved a taken branch or jump this cycle.
- redirect_pc  in  WIDTH  target for a taken branch or jump.
- exc_valid  in  1  exception commit; jump to EXC_PC.
- eret_valid  in  1  eret commit; jump to epc.
- epc  in  WIDTH  return address from CP0.
- call_push  in  1  ID holds jal/jalr; push push_addr.
- push_addr  in  WIDTH  link address (PC of call + 8).
- ret_pop  in  1  ID holds jr $ra; pop the top entry.
- pc  out  WIDTH  current fetch PC (registered).
- ras_top  out  WIDTH  predicted return target; 0 when the stack is empty.
- ras_valid  out  1  stack non-empty.
- ras_overflow  out  1  sticky; set when a push overwrites the oldest entry.
- ras_underflow  out  1  one-cycle pulse on a pop while empty.
- misalign  out  1  one-cycle pulse; the loaded target had bits [1:0] != 0.

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_PC; RAS count=0 and top pointer=0.
  - ras_top=0, ras_valid=0, ras_overflow=0, ras_underflow=0, misalign=0.
  - RAS entry contents are don't-care.
  - Deassertion takes effect at the next rising clk edge.
- PC update each edge, first matching rule wins:
  1. exc_valid -> EXC_PC
  2. eret_valid -> epc
  3. stall -> hold
  4. redirect_valid -> redirect_pc
  5. else -> pc+4, wrapping modulo 2^WIDTH.
- exc and eret override stall. A redirect during a stall is dropped; ID re-presents it after the stall.
- Loaded targets have bits [1:0] forced to 0. misalign pulses on the next cycle when the raw selected target (EXC_PC, epc or redirect_pc) had bits [1:0] != 0.
- Latency: redirect inputs sampled at edge N appear on pc after edge N (one cycle).
- RAS operation (only when stall=0 and exc_valid=0):
  - Push only: top pointer increments modulo RAS_DEPTH and push_addr is written there.
  - Push when count==RAS_DEPTH: the oldest entry is overwritten (circular), count saturates, ras_overflow is set and stays set until reset.
  - Pop only, count>0: top pointer decrements and count decrements.
  - Pop only, count==0: no state change; ras_underflow pulses for 1 cycle.
  - Push and pop together: the top entry is replaced by push_addr; count and pointer are unchanged. If count==0 this acts as a plain push.
- exc_valid clears RAS count to 0; the sticky overflow flag is kept.
- ras_top and ras_valid are combinational from the registered RAS state. A push is visible the cycle after its edge.
- ras_top is a prediction only. The block never redirects on it; ID decides whether to use it as redirect_pc.

Decomposition:
- Shared package/header holds:
  - default RESET_PC and EXC_PC constants;
  - the redirect-priority encoding (EXC, ERET, HOLD, BR, SEQ) as localparams.
- One natural sub-module, ras_stack: circular buffer, pointer, count, overflow/underflow logic.
- The top level keeps the PC register and priority mux.

Test Plan:
- Reset, then 3 free-running cycles with all inputs 0 -> pc = 0x3000, 0x3004, 0x3008, 0x300C; ras_valid=0.
- redirect_valid=1, redirect_pc=0x3100 with stall=1 -> pc holds; next cycle stall=0 with the same redirect -> pc=0x3100.
- exc_valid and redirect_valid together while stalled -> pc=0x4180 and RAS count=0. Then eret_valid, epc=0x3046 -> pc=0x3044 and misalign pulses once.
- Push 0x10, 0x20, 0x30, 0x40, 0x50 with RAS_DEPTH=4 -> ras_overflow=1. Then pops return ras_top = 0x50, 0x40, 0x30, 0x20, and ras_valid=0 after the 4th pop.
- Pop while empty -> ras_underflow pulses 1 cycle, ras_top=0. Simultaneous push 0x60 and pop at count=2 (top 0x20) -> top=0x60, count stays 2.
- pc=0xFFFF_FFFC with no redirect -> next pc=0x0000_0000. reset_n asserted mid-cycle -> pc=0x3000 immediately, without waiting for clk.
